// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between the fetch port (read-only)
// and the data port (read/write), with fairness alternation and a wait watchdog.
module mem_port_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          timeout_err
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_nx;
  logic          grab_if;
  logic          grab_dm;
  logic          finish;
  logic          abort;
  logic [DW-1:0] rdata_nx;

  // State and wait-counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // Next state, request latching strobes and completion/abort decode
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = '0;
    grab_if     = 1'b0;
    grab_dm     = 1'b0;
    finish      = 1'b0;
    abort       = 1'b0;
    unique case (state)
      IDLE: begin
        if (dm_req) begin
          grab_dm  = 1'b1;
          state_nx = BUSY_D;
        end else if (if_req) begin
          grab_if  = 1'b1;
          state_nx = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          finish   = 1'b1;
          state_nx = (state == BUSY_I) ? RESP_I : RESP_D;
        end else if (wait_cnt >= CW'(MAX_WAIT - 1)) begin
          abort       = 1'b1;
          wait_cnt_nx = CW'(MAX_WAIT);
          state_nx    = (state == BUSY_I) ? RESP_I : RESP_D;
        end else begin
          wait_cnt_nx = wait_cnt + CW'(1);
        end
      end
      RESP_D: begin
        // Fetch gets first pick after a data access
        if (if_req) begin
          grab_if  = 1'b1;
          state_nx = BUSY_I;
        end else if (dm_req) begin
          grab_dm  = 1'b1;
          state_nx = BUSY_D;
        end else begin
          state_nx = IDLE;
        end
      end
      RESP_I: begin
        // Data gets first pick after a fetch
        if (dm_req) begin
          grab_dm  = 1'b1;
          state_nx = BUSY_D;
        end else if (if_req) begin
          grab_if  = 1'b1;
          state_nx = BUSY_I;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Aborted reads return zero
  assign rdata_nx = abort ? '0 : mem_rdata;

  // Registered memory request, completion pulses, read data and error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      if_done     <= 1'b0;
      dm_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mem_valid <= (state_nx == BUSY_I) || (state_nx == BUSY_D);
      if_done   <= (state_nx == RESP_I);
      dm_done   <= (state_nx == RESP_D);
      if (grab_dm) begin
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (grab_if) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
      end
      if ((finish || abort) && (state == BUSY_I)) begin
        if_rdata <= rdata_nx;
      end
      if ((finish || abort) && (state == BUSY_D) && !mem_we) begin
        dm_rdata <= rdata_nx;
      end
      if (abort) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Hazard-unit stalls: requester waits until its own done pulse
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = dm_req & ~dm_done;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the fetch stage (read-only) and the memory stage (read/write) of the 5-stage pipeline.
- Grants one requester at a time and drives a valid/ready memory handshake.
- Returns read data, and generates fetch-side and memory-side stall requests for the hazard unit.
- Includes a wait watchdog that aborts hung transactions.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_WAIT, 15, max consecutive cycles in a BUSY state with mem_ready=0 before abort (>=1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request; held until if_done
if_addr  in  AW  fetch address
if_rdata  out  DW  fetch read data, valid when if_done=1
if_done  out  1  one-cycle completion pulse, fetch
dm_req  in  1  data request; held until dm_done
dm_we  in  1  1=write, 0=read
dm_addr  in  AW  data address
dm_wdata  in  DW  write data
dm_rdata  out  DW  data read data, valid when dm_done=1
dm_done  out  1  one-cycle completion pulse, data
mem_valid  out  1  memory request valid
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_ready  in  1  memory accepts/completes the current access this cycle
mem_rdata  in  DW  memory read data, valid with mem_ready
stall_if  out  1  fetch stage must stall
stall_mem  out  1  memory stage must stall
timeout_err  out  1  sticky watchdog error flag

Behaviour:

Reset:
- Asserting reset_n low immediately forces state IDLE and clears the wait counter.
- All outputs go to 0: mem_valid, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_done, dm_done, timeout_err.
- Reset mid-transaction drops mem_valid asynchronously; the in-flight access is abandoned with no done pulse.

States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.

IDLE:
- dm_req=1 -> latch dm_we/dm_addr/dm_wdata, go to BUSY_D.
- Else if_req=1 -> latch if_addr (we=0), go to BUSY_I.
- Else stay.
- Data wins simultaneous requests: the older instruction wins.

BUSY_x:
- mem_valid=1; mem_we/mem_addr/mem_wdata driven from latched registers and stable for the whole transaction.
- Requester inputs are ignored after latching.
- mem_ready=1 -> capture mem_rdata into the port's rdata register (BUSY_I: if_rdata; BUSY_D with we=0: dm_rdata), go to RESP_x.
- On a write, dm_rdata holds its previous value.
- mem_ready=0 -> increment wait counter.
- Counter reaching MAX_WAIT -> abort, go to RESP_x:
  - rdata register of that port (reads only) loaded with 0.
  - timeout_err set to 1; it stays 1 until reset.

RESP_x:
- mem_valid=0; the port's done=1 for exactly this cycle; wait counter cleared.
- Next state, for fairness alternation:
  - RESP_D: if_req=1 -> latch fetch, go to BUSY_I; else if dm_req=1 -> latch, go to BUSY_D; else IDLE.
  - RESP_I: dm_req=1 -> latch data, go to BUSY_D; else if if_req=1 -> go to BUSY_I; else IDLE.
- A requester's req still high in its own RESP cycle is treated as a new request. The pipeline advances on done, so a held req in RESP is the next access.

Latency:
- Request seen in IDLE at cycle 0, mem_ready=1 at cycle 1 -> done at cycle 2.
- Minimum 3 cycles from IDLE, 2 cycles back-to-back via RESP.

Stalls (combinational):
- stall_if = if_req & ~if_done.
- stall_mem = dm_req & ~dm_done.
- Both are 0 when the corresponding req is 0.

mem_ready outside BUSY states: ignored.

Wait counter: width clog2(MAX_WAIT+1); saturates, never wraps.

Test Plan:
- Single fetch: if_req=1, if_addr=0x40; memory gives mem_ready at 2nd BUSY cycle with mem_rdata=0x8C010004 -> mem_addr=0x40, mem_we=0, if_done pulses once with if_rdata=0x8C010004; stall_if=1 every cycle before the done cycle.
- Simultaneous requests: if_req and dm_req (read 0x100) both rise in IDLE -> BUSY_D first (mem_addr=0x100), dm_done, then BUSY_I directly from RESP_D (mem_addr=if_addr) with no IDLE cycle; stall_if=1 throughout.
- Data write: dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_we/addr/wdata stable for all 4 BUSY cycles; dm_done pulses; dm_rdata unchanged.
- Alternation: both reqs held high continuously -> grant order D, I, D, I; each done is a single-cycle pulse.
- Timeout: dm read with mem_ready stuck 0, MAX_WAIT=15 -> after 15 BUSY cycles state goes to RESP_D, dm_done=1, dm_rdata=0, timeout_err=1, still 1 after 10 more idle cycles.
- Reset mid-transaction: reset_n low during BUSY_I -> mem_valid=0 immediately, no if_done; after release, state IDLE and outputs 0; a still-held if_req is re-granted.
